// File: rtl/cpu_rd_pkg.sv
// -----------------------------------------------------------------------------
// cpu_rd_pkg
// Shared definitions for the Z80 read-cycle sequencer, the address/port
// decoders and the data-in mux.
//   state_t       : sequencer FSM states
//   BOOT_*        : bit positions inside the one-hot bootSel vector
//   SRC_*         : req/sel bit index of each data source
// -----------------------------------------------------------------------------
package cpu_rd_pkg;

   typedef enum logic [2:0] {
      BOOT0 = 3'd0,
      BOOT1 = 3'd1,
      BOOT2 = 3'd2,
      IDLE  = 3'd3,
      WAIT  = 3'd4,
      HOLD  = 3'd5
   } state_t;

   // bootSel bit positions: the jump opcode, then the target address bytes
   localparam int BOOT_C3 = 0;
   localparam int BOOT_LO = 1;
   localparam int BOOT_HI = 2;

   // Source indices; a lower index wins when several decoders match
   localparam int SRC_ROM  = 0;
   localparam int SRC_RAM  = 1;
   localparam int SRC_IDE  = 2;
   localparam int SRC_UART = 3;
   localparam int SRC_SD   = 4;
   localparam int SRC_GPIO = 5;
   localparam int SRC_RTC  = 10;

endpackage

// File: rtl/cpu_rd_sequencer_if.sv
// -----------------------------------------------------------------------------
// cpu_rd_sequencer_if
// Bundle between the decoders/CPU side (master) and the read sequencer (slave).
//   rdActive         : Z80 read cycle in progress (level)
//   req              : decoded device selects, bit 0 highest priority
//   sel              : one-hot grant to the data-in mux
//   defaultSel       : no device matched, mux takes S100 data-in
//   bootSel          : one-hot {hi, lo, c3} during the boot jump
//   nWait            : active-low Z80 WAIT
//   busy             : a read cycle is being serviced
//   bootDone         : boot jump finished (sticky)
//   conflict         : one-clock pulse when several req bits hit at grant
//   dbg_state        : current sequencer state
//   dbg_conflict_cnt : saturating conflict count (0 when detection is off)
//
// Handshake: a read is framed by rdActive. Its rising edge requests service;
// the sequencer answers with exactly one select (sel, defaultSel or bootSel)
// and keeps nWait low while the source is not yet ready. The transfer is
// complete when rdActive falls, which retires the select.
// -----------------------------------------------------------------------------
interface cpu_rd_sequencer_if #(
   parameter int NSRC = 16
);
   import cpu_rd_pkg::*;

   logic            rdActive;
   logic [NSRC-1:0] req;
   logic [NSRC-1:0] sel;
   logic            defaultSel;
   logic [2:0]      bootSel;
   logic            nWait;
   logic            busy;
   logic            bootDone;
   logic            conflict;
   state_t          dbg_state;
   logic [7:0]      dbg_conflict_cnt;

   modport master (
      output rdActive, req,
      input  sel, defaultSel, bootSel, nWait, busy, bootDone, conflict,
             dbg_state, dbg_conflict_cnt
   );

   modport slave (
      input  rdActive, req,
      output sel, defaultSel, bootSel, nWait, busy, bootDone, conflict,
             dbg_state, dbg_conflict_cnt
   );

endinterface

// File: rtl/cpu_rd_prienc.sv
// -----------------------------------------------------------------------------
// cpu_rd_prienc
// Combinational priority encoder; bit 0 has the highest priority.
//   req_i   : request vector
//   grant_o : one-hot lowest set bit of req_i (0 when none)
//   none_o  : no request bit set
//   multi_o : more than one request bit set
// -----------------------------------------------------------------------------
module cpu_rd_prienc #(
   parameter int N = 16
) (
   input  logic [N-1:0] req_i,
   output logic [N-1:0] grant_o,
   output logic         none_o,
   output logic         multi_o
);

   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   // Two's-complement trick isolates the lowest set bit
   assign grant_o = req_i & (~req_i + ONE);
   assign none_o  = ~|req_i;
   assign multi_o = |(req_i & ~grant_o);

endmodule

// File: rtl/cpu_rd_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_rd_sequencer
// Drives the Z80 data-in mux selects. The first three reads after reset
// return the boot jump (C3, lo, hi); later reads get a latched one-hot grant
// of the highest-priority decoded source, with wait states for slow sources.
//   pll0_250MHz : system clock (rising edge)
//   n_reset     : synchronous active-low reset
//   bus         : cpu_rd_sequencer_if slave modport (see interface header)
// Optional feature macro RD_CONFLICT_DET_EN: enables the conflict pulse and
// an 8-bit saturating conflict counter; otherwise both read as 0.
// -----------------------------------------------------------------------------
module cpu_rd_sequencer
   import cpu_rd_pkg::*;
#(
   parameter int              NSRC        = 16,
   parameter logic [NSRC-1:0] SLOW_MASK   = '0,
   parameter logic [7:0]      WAIT_CYCLES = 8'd8
) (
   input logic                 pll0_250MHz,
   input logic                 n_reset,
   cpu_rd_sequencer_if.slave   bus
);

   state_t          state_q, state_d;
   logic            rd_q;
   logic            start_q;
   logic [NSRC-1:0] sel_q, sel_d;
   logic            def_q, def_d;
   logic [2:0]      boot_q, boot_d;
   logic            nwait_q, nwait_d;
   logic            done_q, done_d;
   logic [7:0]      cnt_q, cnt_d;

   logic [NSRC-1:0] grant;
   logic            none;
   logic            multi;
   logic            slow_hit;

   cpu_rd_prienc #(.N(NSRC)) u_prienc (
      .req_i   (bus.req),
      .grant_o (grant),
      .none_o  (none),
      .multi_o (multi)
   );

   assign slow_hit = (|(grant & SLOW_MASK)) && (WAIT_CYCLES != 8'd0);

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      def_d   = def_q;
      boot_d  = boot_q;
      nwait_d = nwait_q;
      done_d  = done_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         BOOT0: if (start_q) begin
            boot_d  = 3'b001 << BOOT_C3;
            state_d = HOLD;
         end
         BOOT1: if (start_q) begin
            boot_d  = 3'b001 << BOOT_LO;
            state_d = HOLD;
         end
         BOOT2: if (start_q) begin
            boot_d  = 3'b001 << BOOT_HI;
            state_d = HOLD;
         end
         IDLE: if (start_q) begin
            if (none) begin
               def_d = 1'b1;
            end else begin
               sel_d = grant;
            end
            if (!none && slow_hit) begin
               cnt_d   = WAIT_CYCLES;
               nwait_d = 1'b0;
               state_d = WAIT;
            end else begin
               state_d = HOLD;
            end
         end
         WAIT: begin
            if (!bus.rdActive) begin
               // CPU gave up on the cycle: drop everything
               nwait_d = 1'b1;
               sel_d   = '0;
               def_d   = 1'b0;
               cnt_d   = 8'd0;
               state_d = IDLE;
            end else if (cnt_q <= 8'd1) begin
               nwait_d = 1'b1;
               cnt_d   = 8'd0;
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         HOLD: if (!bus.rdActive) begin
            sel_d  = '0;
            def_d  = 1'b0;
            boot_d = 3'b000;
            if (done_q) begin
               state_d = IDLE;
            end else if (boot_q[BOOT_HI]) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (boot_q[BOOT_LO]) begin
               state_d = BOOT2;
            end else begin
               state_d = BOOT1;
            end
         end
         default: state_d = BOOT0;
      endcase
   end

   always_ff @(posedge pll0_250MHz) begin
      if (!n_reset) begin
         state_q <= BOOT0;
         rd_q    <= 1'b0;
         start_q <= 1'b0;
         sel_q   <= '0;
         def_q   <= 1'b0;
         boot_q  <= 3'b000;
         nwait_q <= 1'b1;
         done_q  <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         rd_q    <= bus.rdActive;
         // Registered edge pulse: selects appear one clock after this
         start_q <= bus.rdActive & ~rd_q;
         sel_q   <= sel_d;
         def_q   <= def_d;
         boot_q  <= boot_d;
         nwait_q <= nwait_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef RD_CONFLICT_DET_EN
   logic       conf_q;
   logic [7:0] ccnt_q;
   logic       conf_hit;

   assign conf_hit = (state_q == IDLE) && start_q && multi;

   always_ff @(posedge pll0_250MHz) begin
      if (!n_reset) begin
         conf_q <= 1'b0;
         ccnt_q <= 8'd0;
      end else begin
         conf_q <= conf_hit;
         if (conf_hit && (ccnt_q != 8'hFF)) begin
            ccnt_q <= ccnt_q + 8'd1;
         end
      end
   end

   assign bus.conflict         = conf_q;
   assign bus.dbg_conflict_cnt = ccnt_q;
`else
   logic unused_multi;
   assign unused_multi         = multi;
   assign bus.conflict         = 1'b0;
   assign bus.dbg_conflict_cnt = 8'd0;
`endif

   assign bus.sel        = sel_q;
   assign bus.defaultSel = def_q;
   assign bus.bootSel    = boot_q;
   assign bus.nWait      = nwait_q;
   assign bus.busy       = (state_q == WAIT) || (state_q == HOLD);
   assign bus.bootDone   = done_q;
   assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_cpu_rd_sequencer.sv
module tb_cpu_rd_sequencer;
   import cpu_rd_pkg::*;

   localparam int          NSRC = 16;
   localparam logic [15:0] SLOW = 16'h0410;
   localparam int          WC   = 4;
   localparam int          W    = NSRC + 8;
`ifdef RD_CONFLICT_DET_EN
   localparam logic CONF_EN = 1'b1;
`else
   localparam logic CONF_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk     = 1'b0;
   logic n_reset = 1'b0;
   always #5 clk = ~clk;

   cpu_rd_sequencer_if #(.NSRC(NSRC)) bus ();

   cpu_rd_sequencer #(
      .NSRC        (NSRC),
      .SLOW_MASK   (SLOW),
      .WAIT_CYCLES (8'(WC))
   ) dut (
      .pll0_250MHz (clk),
      .n_reset     (n_reset),
      .bus         (bus)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- behavioural model ----------------
   // Tracks reads as whole transactions: a pending start opens a read, the
   // read gets its select from the boot count or the lowest set req bit,
   // optionally burns WC wait clocks, and ends when rdActive is seen low.
   logic [W-1:0] exp_q[$];
   logic         m_live = 1'b0;
   logic         m_rd_prev, m_start_pend, m_in_cycle, m_boot_cycle;
   int           m_boot_count, m_wait_left;
   logic [15:0]  m_sel;
   logic         m_def, m_nwait, m_done, m_conf;
   logic [2:0]   m_boot;

   always @(posedge clk) begin : model
      logic        rd;
      logic [15:0] r;
      int          idx, nb;
      rd = bus.rdActive;
      r  = bus.req;
      if (!n_reset) begin
         m_live = 1'b1;
         m_rd_prev = 1'b0; m_start_pend = 1'b0; m_in_cycle = 1'b0;
         m_boot_cycle = 1'b0; m_boot_count = 0; m_wait_left = 0;
         m_sel = '0; m_def = 1'b0; m_boot = 3'b000; m_nwait = 1'b1;
         m_done = 1'b0; m_conf = 1'b0;
      end else if (m_live) begin
         m_conf = 1'b0;
         if (m_in_cycle) begin
            if (!rd) begin
               m_sel = '0; m_def = 1'b0; m_boot = 3'b000; m_nwait = 1'b1;
               m_wait_left = 0; m_in_cycle = 1'b0;
               if (m_boot_cycle && m_boot_count == 3) m_done = 1'b1;
            end else if (m_wait_left > 0) begin
               m_wait_left = m_wait_left - 1;
               if (m_wait_left == 0) m_nwait = 1'b1;
            end
         end else if (m_start_pend) begin
            m_in_cycle = 1'b1;
            if (m_boot_count < 3) begin
               m_boot_cycle = 1'b1;
               m_boot = 3'(1 << m_boot_count);
               m_boot_count = m_boot_count + 1;
            end else begin
               m_boot_cycle = 1'b0;
               idx = -1;
               nb  = 0;
               for (int i = 0; i < NSRC; i++) begin
                  if (r[i]) begin
                     nb = nb + 1;
                     if (idx < 0) idx = i;
                  end
               end
               if (idx < 0) begin
                  m_def = 1'b1;
               end else begin
                  m_sel = 16'(1) << idx;
                  if (SLOW[idx] && WC > 0) begin
                     m_wait_left = WC;
                     m_nwait = 1'b0;
                  end
               end
               m_conf = CONF_EN && (nb > 1);
            end
         end
         m_start_pend = rd && !m_rd_prev;
         m_rd_prev = rd;
      end
      if (m_live)
         exp_q.push_back({m_sel, m_def, m_boot, m_nwait, m_in_cycle, m_done, m_conf});
   end

   // ---------------- scoreboard: every-cycle compare ----------------
   always @(negedge clk) begin : compare
      logic [W-1:0] e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {bus.sel, bus.defaultSel, bus.bootSel, bus.nWait, bus.busy,
              bus.bootDone, bus.conflict};
         checks = checks + 1;
         if (a !== e) begin
            errors = errors + 1;
            $display("FAIL cycle_outputs t=%0t: got %h expected %h", $time, a, e);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_sel"},   32'(bus.sel), 32'h0);
      chk({tag, "_def"},   32'(bus.defaultSel), 32'h0);
      chk({tag, "_boot"},  32'(bus.bootSel), 32'h0);
      chk({tag, "_nwait"}, 32'(bus.nWait), 32'h1);
      chk({tag, "_busy"},  32'(bus.busy), 32'h0);
      chk({tag, "_done"},  32'(bus.bootDone), 32'h0);
      chk({tag, "_conf"},  32'(bus.conflict), 32'h0);
      chk({tag, "_state"}, 32'(bus.dbg_state), 32'(BOOT0));
   endtask

   function automatic logic [15:0] rand_req();
      logic [15:0] v;
      case ($urandom_range(0, 3))
         0: v = 16'h0000;
         1: v = 16'(1) << $urandom_range(0, 15);
         2: v = 16'($urandom);
         default: v = (($urandom_range(0, 1) == 0) ? 16'h0010 : 16'h0400)
                      | (16'($urandom) & 16'hF800);
      endcase
      return v;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int n;
      bus.rdActive = 1'b0;
      bus.req      = '0;
      n_reset      = 1'b0;
      tick(2);
      chk_reset_vals("reset");
      n_reset = 1'b1;
      tick(1);

      // boot jump
      for (int k = 0; k < 3; k++) begin
         bus.rdActive = 1'b1;
         bus.req = 16'hFFFF;
         tick(2);
         chk("boot_sel", 32'(bus.bootSel), 32'(1 << k));
         chk("boot_sel_model", 32'(m_boot), 32'(1 << k));
         chk("boot_sel_nosel", 32'(bus.sel), 32'h0);
         tick(1);
         bus.rdActive = 1'b0;
         tick(1);
         chk("boot_clear", 32'(bus.bootSel), 32'h0);
         chk("boot_done", 32'(bus.bootDone), 32'(k == 2));
      end

      // fourth read, nothing decoded
      bus.req = 16'h0000;
      bus.rdActive = 1'b1;
      tick(2);
      chk("default_sel", 32'(bus.defaultSel), 32'h1);
      chk("default_model", 32'(m_def), 32'h1);
      chk("default_nosel", 32'(bus.sel), 32'h0);
      tick(1);
      bus.rdActive = 1'b0;
      tick(1);
      chk("default_clear", 32'(bus.defaultSel), 32'h0);

      // priority + conflict
      bus.req = 16'h0028;
      bus.rdActive = 1'b1;
      tick(2);
      chk("prio_sel", 32'(bus.sel), 32'h0008);
      chk("prio_sel_model", 32'(m_sel), 32'h0008);
      chk("prio_conflict", 32'(bus.conflict), 32'(CONF_EN));
      tick(1);
      chk("prio_conflict_pulse", 32'(bus.conflict), 32'h0);
      chk("prio_hold", 32'(bus.sel), 32'h0008);
      bus.rdActive = 1'b0;
      tick(1);

      // wait states
      bus.req = 16'h0400;
      bus.rdActive = 1'b1;
      tick(2);
      chk("wait_sel", 32'(bus.sel), 32'h0400);
      n = 0;
      while (bus.nWait == 1'b0 && n < 20) begin
         n = n + 1;
         tick(1);
      end
      chk("wait_len", 32'(n), 32'(WC));
      chk("wait_busy", 32'(bus.busy), 32'h1);
      tick(3);
      chk("wait_hold", 32'(bus.sel), 32'h0400);
      bus.rdActive = 1'b0;
      tick(1);
      chk("wait_end", 32'(bus.sel), 32'h0);

      // abort during wait
      bus.req = 16'h0400;
      bus.rdActive = 1'b1;
      tick(2);
      chk("abort_nwait_low", 32'(bus.nWait), 32'h0);
      tick(1);
      bus.rdActive = 1'b0;
      tick(1);
      chk("abort_nwait", 32'(bus.nWait), 32'h1);
      chk("abort_sel", 32'(bus.sel), 32'h0);
      chk("abort_state", 32'(bus.dbg_state), 32'(IDLE));

      // normal cycle after abort, then req change mid-HOLD
      bus.req = 16'h0004;
      bus.rdActive = 1'b1;
      tick(2);
      chk("after_abort_sel", 32'(bus.sel), 32'h0004);
      tick(1);
      bus.req = 16'h0002;
      tick(2);
      chk("latch_sel", 32'(bus.sel), 32'h0004);
      tick(2);
      chk("latch_sel2", 32'(bus.sel), 32'h0004);
      bus.rdActive = 1'b0;
      tick(1);
      chk("latch_end", 32'(bus.sel), 32'h0);

      // reset in the middle of a wait
      bus.req = 16'h0400;
      bus.rdActive = 1'b1;
      tick(3);
      n_reset = 1'b0;
      bus.rdActive = 1'b0;
      bus.req = '0;
      tick(1);
      chk_reset_vals("midreset");
      n_reset = 1'b1;
      tick(1);
      bus.rdActive = 1'b1;
      tick(2);
      chk("reboot_sel", 32'(bus.bootSel), 32'h1);
      tick(1);
      bus.rdActive = 1'b0;
      tick(1);

      // randomized traffic, checked cycle by cycle against the model
      for (int t = 0; t < 300; t++) begin
         if ($urandom_range(0, 39) == 0) begin
            n_reset = 1'b0;
            bus.rdActive = 1'b0;
            tick($urandom_range(1, 2));
            n_reset = 1'b1;
         end
         tick($urandom_range(1, 3));
         bus.req = rand_req();
         bus.rdActive = 1'b1;
         n = $urandom_range(2, 12);
         for (int h = 0; h < n; h++) begin
            tick(1);
            if ($urandom_range(0, 3) == 0) bus.req = 16'($urandom);
         end
         bus.rdActive = 1'b0;
      end
      tick(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
